spi_slave: RTL and testbench

SPI mode-0 responder that serves as the far end of the team's SPI master on the same 4-wire bus (SCK, CS, MOSI, MISO). It samples MOSI on rising SCK and shifts MISO out on falling SCK, MSB first, 8 bits per byte. It runs from a single system clock and oversamples the external SPI signals through synchronizers. Byte-level handshakes connect it to local logic: a 1-deep transmit holding register and a single-cycle receive strobe.

---
 rtl/spi_slave.sv | 202 ++++++++++++++++++++
 tb/tb_spi_slave.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder (sample MOSI on rising SCK, drive MISO on falling SCK,
// MSB first, 8-bit bytes). SCK, CS and MOSI are oversampled on the system clock through
// SYNC_STAGES-deep synchronizers. Local side: 1-deep tx holding register with valid/ready
// handshake and a single-cycle rx_done strobe.
// Optional feature: define SPI_SLAVE_ERR_EN to add O_err (aborted byte / tx underrun pulse).
module spi_slave #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       I_clk,
   input  logic       I_rst_n,
   input  logic       I_spi_sck,
   input  logic       I_spi_cs,
   input  logic       I_spi_mosi,
   output logic       O_spi_miso,
   input  logic [7:0] I_tx_data,
   input  logic       I_tx_valid,
   output logic       O_tx_ready,
   output logic [7:0] O_rx_data,
   output logic       O_rx_done,
`ifdef SPI_SLAVE_ERR_EN
   output logic       O_err,
`endif
   output logic       O_busy
);

   typedef enum logic [0:0] {StIdle, StActive} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sck_dly_q, sck_dly_d;
   logic                   cs_dly_q, cs_dly_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic                   seen_rise_q, seen_rise_d;
   logic [7:0]             rx_shift_q, rx_shift_d;
   logic [7:0]             tx_shift_q, tx_shift_d;
   logic [7:0]             hold_q, hold_d;
   logic                   hold_full_q, hold_full_d;
   logic                   miso_q, miso_d;
   logic [7:0]             rx_data_q, rx_data_d;
   logic                   rx_done_q, rx_done_d;
   logic                   byte_done_q, byte_done_d;
`ifdef SPI_SLAVE_ERR_EN
   logic                   err_q, err_d;
`endif

   logic sck_s, cs_s, mosi_s;
   logic sck_rise, sck_fall, cs_rise, cs_fall;
   logic load, accept;

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign cs_s     = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_dly_q;
   assign sck_fall = ~sck_s & sck_dly_q;
   assign cs_rise  = cs_s & ~cs_dly_q;
   assign cs_fall  = ~cs_s & cs_dly_q;
   assign accept   = I_tx_valid & ~hold_full_q;

   // Synchronizer shift chains and edge-detect delay flops
   always_comb begin
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], I_spi_sck};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], I_spi_cs};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], I_spi_mosi};
      sck_dly_d   = sck_s;
      cs_dly_d    = cs_s;
   end

   // Frame FSM, shift registers, holding register and rx handoff
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      seen_rise_d = seen_rise_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      miso_d      = miso_q;
      rx_data_d   = rx_data_q;
      rx_done_d   = 1'b0;
      byte_done_d = 1'b0;
      load        = 1'b0;
`ifdef SPI_SLAVE_ERR_EN
      err_d       = 1'b0;
`endif

      unique case (state_q)
         StIdle: begin
            miso_d      = 1'b0;
            bit_cnt_d   = 3'd0;
            rx_shift_d  = 8'h00;
            seen_rise_d = 1'b0;
            if (cs_fall) begin
               state_d = StActive;
               load    = 1'b1;
            end
         end
         StActive: begin
            if (cs_rise) begin
               // Any partial byte is dropped; the holding register is left untouched
               state_d     = StIdle;
               miso_d      = 1'b0;
               bit_cnt_d   = 3'd0;
               rx_shift_d  = 8'h00;
               tx_shift_d  = 8'h00;
               seen_rise_d = 1'b0;
`ifdef SPI_SLAVE_ERR_EN
               err_d       = (bit_cnt_q != 3'd0);
`endif
            end else if (sck_rise) begin
               rx_shift_d  = {rx_shift_q[6:0], mosi_s};
               bit_cnt_d   = bit_cnt_q + 3'd1;
               seen_rise_d = 1'b1;
               byte_done_d = (bit_cnt_q == 3'd7);
            end else if (sck_fall) begin
               if (bit_cnt_q == 3'd0 && seen_rise_q) begin
                  load = 1'b1;
`ifdef SPI_SLAVE_ERR_EN
                  err_d = ~hold_full_q;
`endif
               end else begin
                  tx_shift_d = {tx_shift_q[6:0], 1'b0};
                  miso_d     = tx_shift_q[6];
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // rx_shift_q still holds the full byte in the cycle after the 8th rise
      if (byte_done_q) begin
         rx_data_d = rx_shift_q;
         rx_done_d = 1'b1;
      end

      // Load uses pre-write holding contents; an empty holder sends zeros
      if (load) begin
         tx_shift_d = hold_full_q ? hold_q : 8'h00;
         miso_d     = hold_full_q & hold_q[7];
      end
   end

   // Holding register: accept only when empty, empty on load
   always_comb begin
      hold_d      = accept ? I_tx_data : hold_q;
      hold_full_d = (hold_full_q & ~load) | accept;
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q     <= StIdle;
         sck_sync_q  <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sck_dly_q   <= 1'b0;
         cs_dly_q    <= 1'b1;
         bit_cnt_q   <= 3'd0;
         seen_rise_q <= 1'b0;
         rx_shift_q  <= 8'h00;
         tx_shift_q  <= 8'h00;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         miso_q      <= 1'b0;
         rx_data_q   <= 8'h00;
         rx_done_q   <= 1'b0;
         byte_done_q <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sck_sync_q  <= sck_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sck_dly_q   <= sck_dly_d;
         cs_dly_q    <= cs_dly_d;
         bit_cnt_q   <= bit_cnt_d;
         seen_rise_q <= seen_rise_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         miso_q      <= miso_d;
         rx_data_q   <= rx_data_d;
         rx_done_q   <= rx_done_d;
         byte_done_q <= byte_done_d;
`ifdef SPI_SLAVE_ERR_EN
         err_q       <= err_d;
`endif
      end
   end

   assign O_spi_miso = miso_q;
   assign O_tx_ready = ~hold_full_q;
   assign O_rx_data  = rx_data_q;
   assign O_rx_done  = rx_done_q;
   assign O_busy     = ~cs_s;
`ifdef SPI_SLAVE_ERR_EN
   assign O_err      = err_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave: table of single-byte frames, hand-written corner sequences
// (back-to-back, abort, mid-frame reset, SCK with CS high) and randomized multi-byte frames
// checked against a byte-level model. Checks O_err when SPI_SLAVE_ERR_EN is defined.
module tb_spi_slave;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int HP    = 8;   // SCK half period in system clocks
   localparam int SETUP = 10;  // CS fall to first SCK rise

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sck = 1'b0;
   logic       cs = 1'b1;
   logic       mosi = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       miso, tx_ready, rx_done, busy;
   logic [7:0] rx_data;
`ifdef SPI_SLAVE_ERR_EN
   logic       err;
   int         err_cnt = 0;
   int         err_seen = 0;
`endif

   spi_slave #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .I_clk      (clk),
      .I_rst_n    (rst_n),
      .I_spi_sck  (sck),
      .I_spi_cs   (cs),
      .I_spi_mosi (mosi),
      .O_spi_miso (miso),
      .I_tx_data  (tx_data),
      .I_tx_valid (tx_valid),
      .O_tx_ready (tx_ready),
      .O_rx_data  (rx_data),
      .O_rx_done  (rx_done),
`ifdef SPI_SLAVE_ERR_EN
      .O_err      (err),
`endif
      .O_busy     (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [7:0] tx_q[$];     // bytes local logic will offer, in order
   logic [7:0] rx_hist[$];  // every rx_done capture
   int         rd_idx = 0;
   logic       feed_rdy;

   logic [7:0] fr_mosi[3];
   logic [7:0] fr_miso[3];
   logic [7:0] ex_miso[3];
   logic [7:0] last_rx = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: rx_done captures and error pulses
   always @(negedge clk) begin
      if (rx_done === 1'b1) rx_hist.push_back(rx_data);
`ifdef SPI_SLAVE_ERR_EN
      if (err === 1'b1) err_cnt++;
`endif
   end

   // Local-side feeder: offer queued bytes whenever the holding register is empty
   initial begin
      forever begin
         @(negedge clk);
         if (tx_q.size() > 0) begin
            tx_data  = tx_q[0];
            tx_valid = 1'b1;
            forever begin
               feed_rdy = tx_ready;
               @(posedge clk);
               if (feed_rdy && rst_n) break;
               @(negedge clk);
            end
            #1;
            tx_valid = 1'b0;
            void'(tx_q.pop_front());
         end
      end
   end

   task automatic spi_bit(input logic b, output logic m);
      mosi = b;
      cyc(HP);
      m = miso;  // master samples just before its rising edge
      sck = 1'b1;
      cyc(HP);
      sck = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      logic m;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], m);
         rx[i] = m;
      end
   endtask

   task automatic run_frame(input int k);
      logic [7:0] r;
      cs = 1'b0;
      cyc(SETUP);
      for (int i = 0; i < k; i++) begin
         spi_byte(fr_mosi[i], r);
         fr_miso[i] = r;
      end
      cyc(HP);
      cs = 1'b1;
      cyc(HP + 4);
   endtask

   task automatic check_frame(input string name, input int k, input int exp_err);
      for (int i = 0; i < k; i++)
         check($sformatf("%s miso[%0d]", name, i), fr_miso[i], ex_miso[i]);
      check($sformatf("%s rx_count", name), rx_hist.size() - rd_idx, k);
      for (int i = 0; i < k; i++) begin
         if (rd_idx + i < rx_hist.size())
            check($sformatf("%s rx[%0d]", name, i), rx_hist[rd_idx+i], fr_mosi[i]);
      end
      rd_idx = rx_hist.size();
      if (k > 0) last_rx = fr_mosi[k-1];
      check($sformatf("%s rx_data_hold", name), rx_data, last_rx);
      check($sformatf("%s tx_ready_after", name), tx_ready, 1);
      check($sformatf("%s busy_after", name), busy, 0);
`ifdef SPI_SLAVE_ERR_EN
      check($sformatf("%s err_pulses", name), err_cnt - err_seen, exp_err);
      err_seen = err_cnt;
`else
      if (exp_err < 0) $display("note: negative error expectation");
`endif
   endtask

   task automatic supply(input logic [7:0] b);
      tx_q.push_back(b);
   endtask

   task automatic wait_feed(input string name);
      int n = 0;
      while (tx_q.size() > 0 && n < 200) begin
         cyc(1);
         n++;
      end
      check($sformatf("%s feeder_drained", name), tx_q.size(), 0);
      cyc(2);
   endtask

   typedef struct {
      bit         pre;
      logic [7:0] pre_byte;
      logic [7:0] mosi_byte;
      logic [7:0] exp_miso;
      logic [7:0] exp_rx;
   } vec_t;

   vec_t vecs[4];

   initial begin
      #600000;
      $display("FAIL watchdog actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic m;
      int   k, s;
      logic [7:0] sup[3];

      vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
      vecs[1] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};
      vecs[2] = '{1'b1, 8'h5A, 8'h00, 8'h5A, 8'h00};
      vecs[3] = '{1'b1, 8'hFF, 8'h81, 8'hFF, 8'h81};

      // Reset state
      cyc(3);
      check("rst miso", miso, 0);
      check("rst rx_data", rx_data, 0);
      check("rst rx_done", rx_done, 0);
      check("rst tx_ready", tx_ready, 1);
      check("rst busy", busy, 0);
      rst_n = 1'b1;
      cyc(4);

      // Table: single-byte frames; every one ends with an empty-holder boundary load
      for (int v = 0; v < 4; v++) begin
         if (vecs[v].pre) begin
            supply(vecs[v].pre_byte);
            wait_feed($sformatf("vec%0d", v));
         end
         fr_mosi[0] = vecs[v].mosi_byte;
         ex_miso[0] = vecs[v].exp_miso;
         run_frame(1);
         check_frame($sformatf("vec%0d", v), 1, 1);
         check($sformatf("vec%0d rx_expected", v), last_rx, vecs[v].exp_rx);
      end

      // Back-to-back bytes in one frame, second tx byte supplied on ready
      supply(8'hF0);
      supply(8'h0F);
      cyc(4);
      fr_mosi[0] = 8'h01; fr_mosi[1] = 8'h80;
      ex_miso[0] = 8'hF0; ex_miso[1] = 8'h0F;
      run_frame(2);
      check_frame("b2b", 2, 1);

      // Abort after 5 bits: nothing received, data held
      cs = 1'b0;
      cyc(SETUP);
      for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
      check("abort busy", busy, 1);
      cyc(HP);
      cs = 1'b1;
      cyc(HP + 4);
      check_frame("abort", 0, 1);
      supply(8'hAA);
      wait_feed("post_abort");
      fr_mosi[0] = 8'h55;
      ex_miso[0] = 8'hAA;
      run_frame(1);
      check_frame("post_abort", 1, 1);

      // Reset after 3 bits of a frame
      cs = 1'b0;
      cyc(SETUP);
      for (int i = 0; i < 3; i++) spi_bit(i != 2, m);
      rst_n = 1'b0;
      #1;
      check("midrst miso", miso, 0);
      check("midrst rx_data", rx_data, 0);
      check("midrst rx_done", rx_done, 0);
      check("midrst tx_ready", tx_ready, 1);
      check("midrst busy", busy, 0);
      cs = 1'b1;
      cyc(4);
      rst_n = 1'b1;
      cyc(6);
      last_rx = 8'h00;
      check_frame("midrst_idle", 0, 0);
      supply(8'hC3);
      wait_feed("after_rst");
      fr_mosi[0] = 8'hC3;
      ex_miso[0] = 8'hC3;
      run_frame(1);
      check_frame("after_rst", 1, 1);

      // SCK toggling with CS high is ignored; holding stays full
      supply(8'h11);
      wait_feed("sck_idle");
      check("sck_idle tx_ready_before", tx_ready, 0);
      for (int i = 0; i < 6; i++) begin
         sck = 1'b1;
         cyc(HP);
         check($sformatf("sck_idle miso[%0d]", i), miso, 0);
         sck = 1'b0;
         cyc(HP);
      end
      check("sck_idle tx_ready", tx_ready, 0);
      check("sck_idle rx_count", rx_hist.size() - rd_idx, 0);
      fr_mosi[0] = 8'h22;
      ex_miso[0] = 8'h11;
      run_frame(1);
      check_frame("sck_idle_next", 1, 1);

      // Random frames: byte i on MISO is the i-th supplied byte, zero once supply runs out
      for (int f = 0; f < 20; f++) begin
         k = $urandom_range(1, 3);
         s = $urandom_range(0, k);
         for (int i = 0; i < k; i++) begin
            fr_mosi[i] = 8'($urandom);
            sup[i]     = 8'($urandom);
            ex_miso[i] = (i < s) ? sup[i] : 8'h00;
         end
         for (int i = 0; i < s; i++) supply(sup[i]);
         cyc(4);
         run_frame(k);
         check_frame($sformatf("rnd%0d", f), k, k - ((s > 0) ? s - 1 : 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
